sync_and_n: RTL and testbench

//  Parametrised, registered N-input AND with per-input synchronisation, debounce and masking.

---
 rtl/sync_and_pkg.sv | 19 +
 rtl/debounce_bit.sv | 59 +++++
 rtl/sync_and_n.sv | 98 +++++++++
 tb/tb_sync_and_n.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/sync_and_pkg.sv
// Shared constants and helpers for the synchronised, debounced N-input AND.
package sync_and_pkg;

  localparam int unsigned N_IN_DEF          = 4;
  localparam int unsigned SYNC_STAGES_DEF   = 2;
  localparam int unsigned STABLE_CYCLES_DEF = 8;
  localparam int unsigned GLITCH_W          = 16;

  // Ceiling log2 for sizing counters; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = 32'(i + 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One input lane: multi-flop synchroniser followed by a stability filter.
// abort pulses (registered) the cycle after a pending change is abandoned.
module debounce_bit
  import sync_and_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = SYNC_STAGES_DEF,
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic abort
);

  localparam int unsigned   CW       = clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   filt_q, filt_d;
  logic                   abort_q, abort_d;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  // The threshold branch always returns the counter to zero, so it never wraps.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], d};
    filt_d  = filt_q;
    cnt_d   = '0;
    abort_d = 1'b0;
    if (s == filt_q) begin
      abort_d = (cnt_q != '0);
    end else if (cnt_q == CNT_LAST) begin
      filt_d = s;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      filt_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      filt_q  <= filt_d;
      abort_q <= abort_d;
    end
  end

  assign q     = filt_q;
  assign abort = abort_q;

endmodule

// File: rtl/sync_and_n.sv
// Registered N-input AND of synchronised, debounced, maskable inputs with edge pulses.
// Define GLITCH_CNT_EN to add a saturating count of abandoned input changes.
module sync_and_n
  import sync_and_pkg::*;
#(
  parameter int unsigned N_IN          = N_IN_DEF,
  parameter int unsigned SYNC_STAGES   = SYNC_STAGES_DEF,
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_IN-1:0] din,
  input  logic [N_IN-1:0] mask,
  output logic            dout,
  output logic            dout_rise,
  output logic            dout_fall,
  output logic [N_IN-1:0] filt
`ifdef GLITCH_CNT_EN
  ,
  input  logic                glitch_clr,
  output logic [GLITCH_W-1:0] glitch_cnt
`endif
);

  logic [N_IN-1:0] abort_vec;
  logic            dout_q, dout_d;
  logic            rise_q, rise_d;
  logic            fall_q, fall_d;

  for (genvar i = 0; i < N_IN; i++) begin : g_lane
    debounce_bit #(
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_db (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (din[i]),
      .q    (filt[i]),
      .abort(abort_vec[i])
    );
  end

  // Masked-out lanes read as 1; edges compare the next value against the current one.
  always_comb begin
    dout_d = &(filt | ~mask);
    rise_d = dout_d & ~dout_q;
    fall_d = ~dout_d & dout_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      dout_q <= dout_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign dout      = dout_q;
  assign dout_rise = rise_q;
  assign dout_fall = fall_q;

`ifdef GLITCH_CNT_EN
  localparam int unsigned GSW = GLITCH_W + 1;

  logic [GLITCH_W-1:0] glitch_q, glitch_d;
  logic [GSW-1:0]      glitch_sum;

  // Sum all lanes' aborts in one extra bit so saturation is a carry test; clear has priority.
  always_comb begin
    glitch_sum = GSW'(glitch_q);
    for (int i = 0; i < int'(N_IN); i++) begin
      glitch_sum = glitch_sum + GSW'(abort_vec[i]);
    end
    if (glitch_clr) begin
      glitch_d = '0;
    end else if (glitch_sum[GLITCH_W]) begin
      glitch_d = '1;
    end else begin
      glitch_d = glitch_sum[GLITCH_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) glitch_q <= '0;
    else        glitch_q <= glitch_d;
  end

  assign glitch_cnt = glitch_q;
`else
  logic unused_abort;
  assign unused_abort = ^abort_vec;
`endif

endmodule

// File: tb/tb_sync_and_n.sv
// Randomised + directed bench for sync_and_n with a queue-based scoreboard and run-length model.
module tb_sync_and_n;

  localparam int N  = 4;
  localparam int SS = 2;
  localparam int SC = 8;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] din   = 4'h0;
  logic [3:0] mask  = 4'h0;
  logic       dout, dout_rise, dout_fall;
  logic [3:0] filt;
`ifdef GLITCH_CNT_EN
  logic        glitch_clr = 1'b0;
  logic [15:0] glitch_cnt;
`endif

  always #5 clk = ~clk;

  sync_and_n #(.N_IN(N), .SYNC_STAGES(SS), .STABLE_CYCLES(SC)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (din),
    .mask     (mask),
    .dout     (dout),
    .dout_rise(dout_rise),
    .dout_fall(dout_fall),
    .filt     (filt)
`ifdef GLITCH_CNT_EN
    ,
    .glitch_clr(glitch_clr),
    .glitch_cnt(glitch_cnt)
`endif
  );

  typedef struct packed {
    logic        dout;
    logic        rise;
    logic        fall;
    logic [3:0]  filt;
    logic [15:0] g;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: din delayed SS edges, then a lane flips once it has seen SC
  // consecutive samples disagreeing with its accepted level.
  logic [3:0] m_pipe[$];
  logic [3:0] m_filt;
  int         m_run[N];
  logic       m_dout;
  int         m_g;
  int         m_pend;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pipe.delete();
    for (int i = 0; i < SS; i++) m_pipe.push_back(4'h0);
    m_filt = 4'h0;
    for (int i = 0; i < N; i++) m_run[i] = 0;
    m_dout = 1'b0;
    m_g    = 0;
    m_pend = 0;
  endtask

  task automatic model_step(input logic clr);
    logic [3:0] s, nf;
    logic       dn, r, f;
    int         ab;
    exp_t       e;
    s = m_pipe.pop_front();
    m_pipe.push_back(din);
    dn = &(m_filt | ~mask);
    r  = dn & ~m_dout;
    f  = ~dn & m_dout;
    m_dout = dn;
    m_g = clr ? 0 : ((m_g + m_pend > 65535) ? 65535 : m_g + m_pend);
    ab = 0;
    nf = m_filt;
    for (int i = 0; i < N; i++) begin
      if (s[i] != m_filt[i]) begin
        m_run[i]++;
        if (m_run[i] == SC) begin
          nf[i]    = s[i];
          m_run[i] = 0;
        end
      end else begin
        if (m_run[i] > 0) ab++;
        m_run[i] = 0;
      end
    end
    m_filt = nf;
    m_pend = ab;
    e.dout = m_dout; e.rise = r; e.fall = f; e.filt = m_filt; e.g = 16'(m_g);
    sb.push_back(e);
  endtask

  // One clock of stimulus: drive on the falling edge, advance the model on the rising edge.
  task automatic cyc(input logic [3:0] d, input logic [3:0] m, input logic r, input logic clr);
    @(negedge clk);
    din   = d;
    mask  = m;
    rst_n = r;
`ifdef GLITCH_CNT_EN
    glitch_clr = clr;
`endif
    @(posedge clk);
    if (!r) begin
      model_reset();
      sb.push_back('0);
    end else begin
      model_step(clr);
    end
  endtask

  // Monitor: every cycle the DUT presents a result; pop and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("cycle", 32'({dout, dout_rise, dout_fall, filt}),
              32'({e.dout, e.rise, e.fall, e.filt}));
`ifdef GLITCH_CNT_EN
        check("glitch_cnt", 32'(glitch_cnt), 32'(e.g));
`endif
      end
    end
  end

  initial begin
    int         hit, hit2, pulses;
    logic [3:0] cd, cm;
    logic       rr, cc;
    model_reset();

    // 1: reset with inputs high, then release and time the first rise
    cyc(4'hF, 4'hF, 1'b0, 1'b0);
    cyc(4'hF, 4'hF, 1'b0, 1'b0);
    #1;
    check("rst_outputs", 32'({dout, dout_rise, dout_fall, filt}), 32'h0);
    hit = 0; pulses = 0;
    for (int k = 1; k <= 20; k++) begin
      cyc(4'hF, 4'hF, 1'b1, 1'b0);
      #1;
      if (dout && hit == 0) hit = k;
      if (dout_rise) pulses++;
    end
    check("s1_rise_edge_11_12", 32'(hit >= 11 && hit <= 12), 32'd1);
    check("s1_single_rise", 32'(pulses), 32'd1);

    // 2: 5-cycle dip on din[2] is rejected
    pulses = 0;
    for (int k = 1; k <= 20; k++) begin
      cyc((k <= 5) ? 4'hB : 4'hF, 4'hF, 1'b1, 1'b0);
      #1;
      if (dout_rise || dout_fall || !dout || filt != 4'hF) pulses++;
    end
    check("s2_glitch_rejected", 32'(pulses), 32'd0);
`ifdef GLITCH_CNT_EN
    check("s2_glitch_cnt", 32'(glitch_cnt), 32'd1);
`endif

    // 3: held drop on din[2] is accepted, then dout falls once
    hit = 0; hit2 = 0; pulses = 0;
    for (int k = 1; k <= 20; k++) begin
      cyc(4'hB, 4'hF, 1'b1, 1'b0);
      #1;
      if (!filt[2] && hit == 0) hit = k;
      if (dout_fall) begin pulses++; hit2 = k; end
    end
    check("s3_filt_edge_10_11", 32'(hit >= 10 && hit <= 11), 32'd1);
    check("s3_fall_after_filt", 32'(hit2), 32'(hit + 1));
    check("s3_single_fall", 32'(pulses), 32'd1);

    // 4: masking the low input out raises dout on the next edge; mask=0 keeps it high
    cyc(4'hB, 4'b1011, 1'b1, 1'b0);
    #1;
    check("s4_mask_rise", 32'({dout, dout_rise}), 32'b11);
    cyc(4'hB, 4'h0, 1'b1, 1'b0);
    #1;
    check("s4_mask0_high", 32'({dout, dout_fall}), 32'b10);

    // 5: reset in the middle of a debounce count
    for (int k = 0; k < 5; k++) cyc(4'hF, 4'hF, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("s5_async_clear", 32'({dout, dout_rise, dout_fall, filt}), 32'h0);
    cyc(4'hF, 4'hF, 1'b0, 1'b0);
    hit = 0;
    for (int k = 1; k <= 20; k++) begin
      cyc(4'hF, 4'hF, 1'b1, 1'b0);
      #1;
      if (dout && hit == 0) hit = k;
    end
    check("s5_full_reacceptance", 32'(hit >= 11 && hit <= 12), 32'd1);

    // Random phase: slow-moving inputs with short glitches, mask changes, rare resets
    cd = 4'hF; cm = 4'hF;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(0, 11) == 0) cd[i] = ~cd[i];
      if ($urandom_range(0, 49) == 0) cm = 4'($urandom);
      rr = ($urandom_range(0, 799) != 0);
      cc = ($urandom_range(0, 99) == 0);
      cyc(cd, cm, rr, cc);
    end

`ifdef GLITCH_CNT_EN
    // 6: saturate the glitch counter, then clear it while glitches keep arriving
    cyc(4'hF, 4'hF, 1'b1, 1'b1);
    for (int k = 0; k < 14; k++) cyc(4'hF, 4'hF, 1'b1, 1'b1);
    for (int k = 0; k < 33000; k++) cyc((k % 2 == 0) ? 4'h0 : 4'hF, 4'hF, 1'b1, 1'b0);
    #1;
    check("s6_saturated", 32'(glitch_cnt), 32'hFFFF);
    cyc(4'h0, 4'hF, 1'b1, 1'b1);
    #1;
    check("s6_clear_wins", 32'(glitch_cnt), 32'h0);
`endif

    repeat (3) @(posedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
